// File: rtl/ibex_wb_queue.sv
// In-order writeback queue between ID/EX and the register file. Holds up to Depth
// instructions so several loads/stores can be outstanding, with per-port forwarding/hazards.
module ibex_wb_queue #(
  parameter int unsigned Depth             = 2,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        en_wb_i,
  input  logic [1:0]  instr_type_wb_i,
  input  logic [31:0] pc_id_i,
  input  logic        instr_is_compressed_id_i,
  input  logic        instr_perf_count_id_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] rf_wdata_id_i,
  input  logic        rf_we_id_i,
  input  logic        dummy_instr_id_i,

  input  logic [4:0]  rf_raddr_a_i,
  input  logic [4:0]  rf_raddr_b_i,

  input  logic [31:0] rf_wdata_lsu_i,
  input  logic        rf_we_lsu_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,

  output logic        ready_wb_o,
  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,
  output logic        rf_we_wb_o,

  output logic        fwd_a_valid_o,
  output logic [31:0] fwd_a_data_o,
  output logic        fwd_b_valid_o,
  output logic [31:0] fwd_b_data_o,
  output logic        hazard_a_o,
  output logic        hazard_b_o,

  output logic        outstanding_load_wb_o,
  output logic        outstanding_store_wb_o,
  output logic [3:0]  occupancy_o,
  output logic [31:0] pc_wb_o,
  output logic        instr_done_wb_o,
  output logic        perf_instr_ret_wb_o,
  output logic        perf_instr_ret_compressed_wb_o,
  output logic        dummy_instr_wb_o,
  output logic        resp_unexpected_o
);

  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0]  DepthCnt = 4'(Depth);

  // wb_instr_type_e encoding
  localparam logic [1:0] WbInstrLoad  = 2'd0;
  localparam logic [1:0] WbInstrStore = 2'd1;
  localparam logic [1:0] WbInstrOther = 2'd2;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (32'(p) == Depth - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Control state
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [3:0]       count_q, count_d;

  // Entry payload (not reset)
  logic [1:0]       type_q  [Depth];
  logic [31:0]      pc_q    [Depth];
  logic [4:0]       waddr_q [Depth];
  logic [31:0]      wdata_q [Depth];
  logic [Depth-1:0] we_q;
  logic [Depth-1:0] compressed_q;
  logic [Depth-1:0] perf_q;
  logic [Depth-1:0] dummy_q;

  logic       head_valid;
  logic [1:0] head_type;
  logic       head_done;
  logic       enq;
  logic       src_wb;

  assign head_valid = valid_q[head_q];
  assign head_type  = type_q[head_q];
  assign head_done  = head_valid & ((head_type == WbInstrOther) | lsu_resp_valid_i);

  // A full queue still accepts when the head retires in the same cycle.
  assign ready_wb_o = (count_q < DepthCnt) | head_done;
  assign enq        = en_wb_i & ready_wb_o;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (head_done) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    // Enqueue after retire so a simultaneous full-queue swap keeps the slot valid.
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end
    case ({enq, head_done})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      type_q[tail_q]       <= instr_type_wb_i;
      pc_q[tail_q]         <= pc_id_i;
      waddr_q[tail_q]      <= rf_waddr_id_i;
      wdata_q[tail_q]      <= rf_wdata_id_i;
      we_q[tail_q]         <= rf_we_id_i;
      compressed_q[tail_q] <= instr_is_compressed_id_i;
      perf_q[tail_q]       <= instr_perf_count_id_i;
      dummy_q[tail_q]      <= DummyInstructions & dummy_instr_id_i;
    end
  end

  // Forwarding search from oldest to youngest; later matches overwrite earlier ones.
  logic            match_a, match_b;
  logic [PtrW-1:0] midx_a, midx_b;

  always_comb begin
    logic [PtrW-1:0] idx;
    match_a = 1'b0;
    match_b = 1'b0;
    midx_a  = '0;
    midx_b  = '0;
    idx     = head_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[idx] && (we_q[idx] || (type_q[idx] == WbInstrLoad))) begin
        if ((rf_raddr_a_i != 5'd0) && (waddr_q[idx] == rf_raddr_a_i)) begin
          match_a = 1'b1;
          midx_a  = idx;
        end
        if ((rf_raddr_b_i != 5'd0) && (waddr_q[idx] == rf_raddr_b_i)) begin
          match_b = 1'b1;
          midx_b  = idx;
        end
      end
      idx = ptr_inc(idx);
    end
  end

  assign fwd_a_valid_o = match_a & (type_q[midx_a] == WbInstrOther);
  assign hazard_a_o    = match_a & (type_q[midx_a] == WbInstrLoad);
  assign fwd_a_data_o  = fwd_a_valid_o ? wdata_q[midx_a] : 32'd0;
  assign fwd_b_valid_o = match_b & (type_q[midx_b] == WbInstrOther);
  assign hazard_b_o    = match_b & (type_q[midx_b] == WbInstrLoad);
  assign fwd_b_data_o  = fwd_b_valid_o ? wdata_q[midx_b] : 32'd0;

  always_comb begin
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i] && (type_q[i] == WbInstrLoad)) begin
        outstanding_load_wb_o = 1'b1;
      end
      if (valid_q[i] && (type_q[i] == WbInstrStore)) begin
        outstanding_store_wb_o = 1'b1;
      end
    end
  end

  // Register-file write: completed non-load head result, or load data from the LSU.
  assign src_wb        = head_valid & (head_type == WbInstrOther) & we_q[head_q];
  assign rf_we_wb_o    = src_wb | rf_we_lsu_i;
  assign rf_wdata_wb_o = ({32{src_wb}} & wdata_q[head_q]) | ({32{rf_we_lsu_i}} & rf_wdata_lsu_i);
  assign rf_waddr_wb_o = head_valid ? waddr_q[head_q] : 5'd0;

  assign occupancy_o       = count_q;
  assign pc_wb_o           = head_valid ? pc_q[head_q] : 32'd0;
  assign instr_done_wb_o   = head_done;
  assign dummy_instr_wb_o  = DummyInstructions & head_valid & dummy_q[head_q];
  assign resp_unexpected_o = lsu_resp_valid_i & (~head_valid | (head_type == WbInstrOther));

  assign perf_instr_ret_wb_o = head_done & perf_q[head_q] & ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & compressed_q[head_q];

`ifndef SYNTHESIS
  rf_write_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    !(src_wb && rf_we_lsu_i));
`endif

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Directed bench for ibex_wb_queue (Depth=2); a scoreboard tracks retire order and RF writes.
module tb_ibex_wb_queue;

  localparam logic [1:0] TLoad  = 2'd0;
  localparam logic [1:0] TStore = 2'd1;
  localparam logic [1:0] TOther = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_wb_i;
  logic [1:0]  instr_type_wb_i;
  logic [31:0] pc_id_i;
  logic        instr_is_compressed_id_i;
  logic        instr_perf_count_id_i;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic        dummy_instr_id_i;
  logic [4:0]  rf_raddr_a_i;
  logic [4:0]  rf_raddr_b_i;
  logic [31:0] rf_wdata_lsu_i;
  logic        rf_we_lsu_i;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic        ready_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic        fwd_a_valid_o;
  logic [31:0] fwd_a_data_o;
  logic        fwd_b_valid_o;
  logic [31:0] fwd_b_data_o;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic        outstanding_load_wb_o;
  logic        outstanding_store_wb_o;
  logic [3:0]  occupancy_o;
  logic [31:0] pc_wb_o;
  logic        instr_done_wb_o;
  logic        perf_instr_ret_wb_o;
  logic        perf_instr_ret_compressed_wb_o;
  logic        dummy_instr_wb_o;
  logic        resp_unexpected_o;

  ibex_wb_queue dut (
    .clk_i                          (clk_i),
    .rst_i                          (rst_i),
    .en_wb_i                        (en_wb_i),
    .instr_type_wb_i                (instr_type_wb_i),
    .pc_id_i                        (pc_id_i),
    .instr_is_compressed_id_i       (instr_is_compressed_id_i),
    .instr_perf_count_id_i          (instr_perf_count_id_i),
    .rf_waddr_id_i                  (rf_waddr_id_i),
    .rf_wdata_id_i                  (rf_wdata_id_i),
    .rf_we_id_i                     (rf_we_id_i),
    .dummy_instr_id_i               (dummy_instr_id_i),
    .rf_raddr_a_i                   (rf_raddr_a_i),
    .rf_raddr_b_i                   (rf_raddr_b_i),
    .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
    .rf_we_lsu_i                    (rf_we_lsu_i),
    .lsu_resp_valid_i               (lsu_resp_valid_i),
    .lsu_resp_err_i                 (lsu_resp_err_i),
    .ready_wb_o                     (ready_wb_o),
    .rf_waddr_wb_o                  (rf_waddr_wb_o),
    .rf_wdata_wb_o                  (rf_wdata_wb_o),
    .rf_we_wb_o                     (rf_we_wb_o),
    .fwd_a_valid_o                  (fwd_a_valid_o),
    .fwd_a_data_o                   (fwd_a_data_o),
    .fwd_b_valid_o                  (fwd_b_valid_o),
    .fwd_b_data_o                   (fwd_b_data_o),
    .hazard_a_o                     (hazard_a_o),
    .hazard_b_o                     (hazard_b_o),
    .outstanding_load_wb_o          (outstanding_load_wb_o),
    .outstanding_store_wb_o         (outstanding_store_wb_o),
    .occupancy_o                    (occupancy_o),
    .pc_wb_o                        (pc_wb_o),
    .instr_done_wb_o                (instr_done_wb_o),
    .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
    .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o),
    .dummy_instr_wb_o               (dummy_instr_wb_o),
    .resp_unexpected_o              (resp_unexpected_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    en_wb_i          = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    rf_we_lsu_i      = 1'b0;
    rf_wdata_lsu_i   = 32'd0;
  endtask

  task automatic enq(input logic [1:0] t, input logic [31:0] pc, input logic [4:0] wa,
                     input logic [31:0] wd, input logic we, input logic perf, input logic comp);
    en_wb_i                  = 1'b1;
    instr_type_wb_i          = t;
    pc_id_i                  = pc;
    rf_waddr_id_i            = wa;
    rf_wdata_id_i            = wd;
    rf_we_id_i               = we;
    instr_perf_count_id_i    = perf;
    instr_is_compressed_id_i = comp;
  endtask

  // Scoreboard: push on accepted enqueue, pop and compare on retire.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      sb.delete();
    end else begin
      if (instr_done_wb_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_underflow: observed retire pc %0h expected no retire", pc_wb_o);
        end else begin
          e = sb.pop_front();
          chk("retire_pc", pc_wb_o, e.pc);
          if (e.wr) begin
            chk("retire_we", 32'(rf_we_wb_o), 32'd1);
            chk("retire_waddr", 32'(rf_waddr_wb_o), 32'(e.waddr));
            chk("retire_wdata", rf_wdata_wb_o, e.wdata);
          end
        end
      end
      if (en_wb_i && ready_wb_o) begin
        e.pc    = pc_id_i;
        e.wr    = (instr_type_wb_i == TOther) && rf_we_id_i;
        e.waddr = rf_waddr_id_i;
        e.wdata = rf_wdata_id_i;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    idle();
    instr_type_wb_i = TOther; pc_id_i = '0; rf_waddr_id_i = '0; rf_wdata_id_i = '0;
    rf_we_id_i = 1'b0; instr_perf_count_id_i = 1'b0; instr_is_compressed_id_i = 1'b0;
    dummy_instr_id_i = 1'b0; rf_raddr_a_i = '0; rf_raddr_b_i = '0;
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    // Reset state
    chk("rst_ready", 32'(ready_wb_o), 32'd1);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_pc", pc_wb_o, 32'd0);
    chk("rst_done", 32'(instr_done_wb_o), 32'd0);
    chk("rst_haz", 32'({hazard_a_o, hazard_b_o, fwd_a_valid_o, fwd_b_valid_o}), 32'd0);
    chk("rst_outst", 32'({outstanding_load_wb_o, outstanding_store_wb_o}), 32'd0);
    chk("rst_misc", 32'({resp_unexpected_o, rf_we_wb_o, perf_instr_ret_wb_o, dummy_instr_wb_o}),
        32'd0);
    rf_we_lsu_i = 1'b1; rf_wdata_lsu_i = 32'hA5;
    #1;
    chk("lsu_pass_wdata", rf_wdata_wb_o, 32'hA5);
    chk("lsu_pass_we", 32'(rf_we_wb_o), 32'd1);
    cyc(); idle();

    // LOAD x5 then OTHER x6 fills the queue
    enq(TLoad, 32'h100, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    enq(TOther, 32'h104, 5'd6, 32'h1234, 1'b1, 1'b1, 1'b0);
    cyc();
    en_wb_i = 1'b0; rf_raddr_a_i = 5'd5; rf_raddr_b_i = 5'd6;
    #1;
    chk("full_occ", 32'(occupancy_o), 32'd2);
    chk("full_ready", 32'(ready_wb_o), 32'd0);
    chk("haz_a", 32'(hazard_a_o), 32'd1);
    chk("haz_a_nofwd", 32'(fwd_a_valid_o), 32'd0);
    chk("fwd_b_valid", 32'(fwd_b_valid_o), 32'd1);
    chk("fwd_b_data", fwd_b_data_o, 32'h1234);
    chk("haz_b", 32'(hazard_b_o), 32'd0);
    chk("outst_load", 32'(outstanding_load_wb_o), 32'd1);
    chk("head_pc", pc_wb_o, 32'h100);

    // Load response and enqueue in the same cycle while full
    lsu_resp_valid_i = 1'b1; rf_we_lsu_i = 1'b1; rf_wdata_lsu_i = 32'hBEEF;
    enq(TOther, 32'h108, 5'd7, 32'h1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("swap_done", 32'(instr_done_wb_o), 32'd1);
    chk("swap_ready", 32'(ready_wb_o), 32'd1);
    chk("swap_perf", 32'(perf_instr_ret_wb_o), 32'd1);
    chk("swap_lsu_wdata", rf_wdata_wb_o, 32'hBEEF);
    chk("swap_unexp", 32'(resp_unexpected_o), 32'd0);
    cyc(); idle();
    enq(TOther, 32'h10C, 5'd7, 32'h2, 1'b1, 1'b1, 1'b0);
    rf_raddr_a_i = 5'd7;
    #1;
    chk("swap_occ", 32'(occupancy_o), 32'd2);
    chk("x6_waddr", 32'(rf_waddr_wb_o), 32'd6);
    chk("x6_wdata", rf_wdata_wb_o, 32'h1234);
    chk("fwd_a_old", fwd_a_data_o, 32'h1);
    cyc();
    en_wb_i = 1'b0;
    #1;
    chk("youngest_valid", 32'(fwd_a_valid_o), 32'd1);
    chk("youngest_data", fwd_a_data_o, 32'h2);
    chk("x7a_wdata", rf_wdata_wb_o, 32'h1);
    chk("x7_occ", 32'(occupancy_o), 32'd2);
    cyc();
    chk("x7b_wdata", rf_wdata_wb_o, 32'h2);
    chk("x7b_occ", 32'(occupancy_o), 32'd1);
    cyc();
    chk("drain_occ", 32'(occupancy_o), 32'd0);

    // Load with error response suppresses retire counters
    enq(TLoad, 32'h200, 5'd8, 32'd0, 1'b0, 1'b1, 1'b1);
    cyc();
    en_wb_i = 1'b0; lsu_resp_valid_i = 1'b1; lsu_resp_err_i = 1'b1;
    #1;
    chk("err_done", 32'(instr_done_wb_o), 32'd1);
    chk("err_perf", 32'(perf_instr_ret_wb_o), 32'd0);
    chk("err_perf_c", 32'(perf_instr_ret_compressed_wb_o), 32'd0);
    cyc(); idle();
    enq(TStore, 32'h204, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cyc();
    en_wb_i = 1'b0;
    #1;
    chk("store_outst", 32'(outstanding_store_wb_o), 32'd1);
    chk("store_wait", 32'(instr_done_wb_o), 32'd0);
    lsu_resp_valid_i = 1'b1;
    #1;
    chk("store_done", 32'(instr_done_wb_o), 32'd1);
    chk("store_perf", 32'(perf_instr_ret_wb_o), 32'd1);
    chk("store_perf_c", 32'(perf_instr_ret_compressed_wb_o), 32'd1);
    cyc(); idle();
    #1;
    chk("store_occ", 32'(occupancy_o), 32'd0);

    // Unexpected responses
    lsu_resp_valid_i = 1'b1;
    #1;
    chk("unexp_empty", 32'(resp_unexpected_o), 32'd1);
    chk("unexp_nodone", 32'(instr_done_wb_o), 32'd0);
    cyc(); idle();
    #1;
    chk("unexp_occ", 32'(occupancy_o), 32'd0);
    enq(TOther, 32'h300, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0);
    cyc();
    en_wb_i = 1'b0; rf_raddr_a_i = 5'd0; lsu_resp_valid_i = 1'b1;
    #1;
    chk("x0_nofwd", 32'(fwd_a_valid_o), 32'd0);
    chk("x0_data", fwd_a_data_o, 32'd0);
    chk("unexp_other", 32'(resp_unexpected_o), 32'd1);
    chk("other_perf_off", 32'(perf_instr_ret_wb_o), 32'd0);
    cyc(); idle();

    // Reset with two in-flight entries
    enq(TLoad, 32'h400, 5'd10, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    enq(TLoad, 32'h404, 5'd11, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    en_wb_i = 1'b0;
    #1;
    chk("prerst_occ", 32'(occupancy_o), 32'd2);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("midrst_occ", 32'(occupancy_o), 32'd0);
    chk("midrst_done", 32'(instr_done_wb_o), 32'd0);
    chk("midrst_ready", 32'(ready_wb_o), 32'd1);
    chk("midrst_load", 32'(outstanding_load_wb_o), 32'd0);
    chk("midrst_pc", pc_wb_o, 32'd0);

    // One-cycle latency after reset
    enq(TOther, 32'h500, 5'd12, 32'hCAFE, 1'b1, 1'b1, 1'b0);
    cyc();
    en_wb_i = 1'b0;
    #1;
    chk("lat_we", 32'(rf_we_wb_o), 32'd1);
    chk("lat_waddr", 32'(rf_waddr_wb_o), 32'd12);
    chk("lat_wdata", rf_wdata_wb_o, 32'hCAFE);
    cyc(); cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
